// File: rtl/operand_loader_pkg.sv
// -----------------------------------------------------------------------------
// operand_loader_pkg
// Shared definitions for the operand loader: loader FSM state encoding,
// operand geometry constants and a byte-lane insertion helper.
// -----------------------------------------------------------------------------
package operand_loader_pkg;

  localparam int BYTES_PER_OPERAND = 4;
  localparam int OPERAND_W         = 32;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    ADD    = 2'd2,
    OUT    = 2'd3
  } state_t;

  // Write byte b into operand op at stream position idx.
  // With le set, stream byte 0 is the least significant lane; otherwise
  // stream byte 0 is the most significant lane.
  function automatic logic [OPERAND_W-1:0] place_byte(
    input logic [OPERAND_W-1:0] op,
    input logic [7:0]           b,
    input logic [1:0]           idx,
    input logic                 le
  );
    logic [OPERAND_W-1:0] r;
    logic [1:0]           lane;
    r    = op;
    lane = le ? idx : (2'd3 - idx);
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/operand_loader_adder32.sv
// -----------------------------------------------------------------------------
// adder32
// Plain 32-bit unsigned adder, result = a + b (mod 2^32).
// Ports:
//   a, b    : 32-bit operands
//   result  : 32-bit sum, carry-out discarded
// -----------------------------------------------------------------------------
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  assign result = a + b;

endmodule

// File: rtl/operand_loader.sv
// -----------------------------------------------------------------------------
// operand_loader
// Collects two 32-bit operands from an 8-bit byte stream (A first, then B),
// adds them through adder32 and presents a registered sum plus carry-out
// behind a valid/ready handshake.
//
// Parameters:
//   BYTE_ORDER_LE : 1 = first stream byte lands in bits [7:0],
//                   0 = first stream byte lands in bits [31:24]
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   in_data   : operand byte stream
//   in_valid  : in_data valid
//   in_ready  : byte accepted this cycle when in_valid is also high
//   res_data  : registered A+B mod 2^32
//   res_carry : unsigned carry-out of A+B
//   res_valid : res_data / res_carry valid
//   res_ready : consumer accepts the result
//   busy      : low only when idle at the start of operand A
//
// state  | meaning
// -------+----------------------------------------------------------
// LOAD_A | accepting operand A bytes, count = next byte position
// LOAD_B | accepting operand B bytes, count = next byte position
// ADD    | single cycle: register adder sum and carry
// OUT    | result presented, waiting for res_ready
// -----------------------------------------------------------------------------
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int BYTE_ORDER_LE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OPERAND_W-1:0] res_data,
  output logic                 res_carry,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 busy
);

  localparam logic LE = (BYTE_ORDER_LE != 0);

  state_t               state;
  logic [1:0]           count;
  logic [OPERAND_W-1:0] op_a;
  logic [OPERAND_W-1:0] op_b;
  logic [OPERAND_W-1:0] sum;
  logic                 accept;

  adder32 u_adder32 (
    .a      (op_a),
    .b      (op_b),
    .result (sum)
  );

  // in_ready is gated by rst_n so no byte appears accepted during reset,
  // even though the state register is only cleared at the edge.
  assign in_ready = rst_n && ((state == LOAD_A) || (state == LOAD_B));
  assign accept   = in_valid && in_ready;
  assign busy     = !((state == LOAD_A) && (count == 2'd0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= LOAD_A;
      count     <= 2'd0;
      op_a      <= '0;
      op_b      <= '0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          if (accept) begin
            op_a  <= place_byte(op_a, in_data, count, LE);
            count <= count + 2'd1;   // wraps to 0 after the fourth byte
            if (count == 2'(BYTES_PER_OPERAND - 1)) begin
              state <= LOAD_B;
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            op_b  <= place_byte(op_b, in_data, count, LE);
            count <= count + 2'd1;
            if (count == 2'(BYTES_PER_OPERAND - 1)) begin
              state <= ADD;
            end
          end
        end
        ADD: begin
          res_data  <= sum;
          // A wrapped sum is smaller than either addend exactly when the
          // true sum overflowed 32 bits.
          res_carry <= (sum < op_a);
          res_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            count     <= 2'd0;
            state     <= LOAD_A;
          end
        end
        default: begin
          state <= LOAD_A;
          count <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 SHALL have parameter BYTE_ORDER_LE, default 1: 1 = first byte of each operand lands in bits [7:0]; 0 = first byte lands in bits [31:24].
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port in_data, input, 8: operand byte stream; operand A bytes first, then operand B bytes.
REQ-005 SHALL have port in_valid, input, 1: in_data is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1: block accepts a byte this cycle.
REQ-007 SHALL have port res_data, output, 32: registered A+B, mod 2^32.
REQ-008 SHALL have port res_carry, output, 1: unsigned carry-out of A+B.
REQ-009 SHALL have port res_valid, output, 1: res_data and res_carry are valid.
REQ-010 SHALL have port res_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have port busy, output, 1: high in every state except LOAD_A with byte count 0.

Function
REQ-012 SHALL implement FSM states LOAD_A, LOAD_B, ADD and OUT.
REQ-013 SHALL accept a byte only when in_valid && in_ready; in_ready = 1 only in LOAD_A and LOAD_B.
REQ-014 SHALL use a 2-bit byte counter: increment per accepted byte; in LOAD_A, count==3 accepted -> LOAD_B, count wraps to 0; in LOAD_B, count==3 accepted -> ADD.
REQ-015 SHALL place byte k (k = 0..3) into bits [8k+7:8k] when BYTE_ORDER_LE=1, and into bits [31-8k:24-8k] when BYTE_ORDER_LE=0.
REQ-016 SHALL, with in_valid low, hold state, count and partial operands unchanged; idle gaps are legal anywhere in the stream.
REQ-017 SHALL, in ADD (exactly one cycle), feed registered A and B to the adder and register its sum into res_data, then go to OUT.
REQ-018 SHALL compute res_carry = 1 when the registered sum < A (unsigned).
REQ-019 SHALL have latency: last B byte accepted at cycle t -> ADD at t+1 -> res_valid high from t+2.
REQ-020 SHALL hold res_valid, res_data and res_carry stable in OUT until res_ready is high.
REQ-021 SHALL, on res_valid && res_ready, go to LOAD_A with count 0; in_ready rises the next cycle.
REQ-022 SHALL keep in_ready = 0 in ADD and OUT; no overlap of loading and output.
REQ-023 SHALL leave res_data unchanged outside ADD.

Reset
REQ-024 SHALL, when rst_n is low at a clock edge, set state = LOAD_A, count = 0, A = 0, B = 0, res_data = 0, res_carry = 0 and res_valid = 0.
REQ-025 SHALL, on reset during any state (including mid-operand or OUT), discard partial bytes and any pending result; a stalled res_valid drops without a handshake.
REQ-026 SHALL hold in_ready at 0 during any cycle in which rst_n is low.

Structure
REQ-027 SHALL place in a shared package: the FSM state typedef (LOAD_A, LOAD_B, ADD, OUT) and constants BYTES_PER_OPERAND = 4 and OPERAND_W = 32.
REQ-028 SHALL instantiate the existing adder32 (ports a, b, result) as its sole sub-module, with A and B registers driving a and b.
REQ-029 SHALL keep carry logic and result registers in operand_loader; adder32 SHALL NOT be modified.

Verification
REQ-030 SHALL verify basic add: A = 0x00000000, B = 0x00000001 as back-to-back bytes, res_ready = 1 -> res_data = 0x00000001, res_carry = 0, res_valid high for exactly 1 cycle, 2 cycles after the last byte.
REQ-031 SHALL verify wrap-around: A = 0xFFFFFFFF, B = 0x00000001 -> res_data = 0x00000000, res_carry = 1.
REQ-032 SHALL verify backpressure: A = 0x00002712, B = 0x000003E8, res_ready low for 5 cycles -> res_data = 0x00002AFA held stable, in_ready = 0 throughout, then acceptance and in_ready = 1 the next cycle.
REQ-033 SHALL verify stream gaps: A = 0x12345678, B = 0x11111111 with in_valid low for 3 cycles between every byte -> res_data = 0x23456789.
REQ-034 SHALL verify reset mid-load: 5 bytes sent, rst_n low for 1 cycle, then A = 5, B = 7 -> res_data = 0x0000000C, no stale bytes in the result.
REQ-035 SHALL verify byte order: BYTE_ORDER_LE = 0, bytes 0x01 0x02 0x03 0x04 for A and 0x00 0x00 0x00 0x01 for B -> res_data = 0x01020305.
